tt_sweep_capture: RTL and testbench

TT_SWEEP_CAPTURE -- requirements
Module: tt_sweep_capture

---
 rtl/tt_sweep_capture.sv | 157 +++++++++++++++
 tb/tb_tt_sweep_capture.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_capture.sv
// ---------------------------------------------------------------------------
// tt_sweep_capture
// Drives every 7-bit input vector onto an external single-output function,
// optionally waits SETTLE cycles per vector, and captures the full 128-entry
// truth table plus its population count.
//
// Parameters
//   SETTLE   extra wait cycles per vector before f_in is sampled (0..15)
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     request a sweep (accepted only when idle)
//   x[6:0]    vector driven to the function under test
//   f_in      function output for the current x
//   busy      high while vectors are being applied/sampled
//   done      one-cycle pulse when the sweep completes
//   tt[127:0] captured table, tt[i] = f(i)
//   weight    number of ones in tt
//
// Optional build macro TT_SWEEP_COMPARE_EN adds:
//   expected[127:0]  reference table
//   match            registered (tt == expected), updated when the sweep ends
// ---------------------------------------------------------------------------
module tt_sweep_capture #(
  parameter int unsigned SETTLE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [6:0]   x,
  input  logic         f_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] tt,
  output logic [7:0]   weight
`ifdef TT_SWEEP_COMPARE_EN
  ,
  input  logic [127:0] expected,
  output logic         match
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned X_W   = 7;
  localparam int unsigned W_W   = 8;
  localparam bit          HAS_SETTLE = (SETTLE > 0);
  // Last count value spent in SETTLE; unused when SETTLE == 0.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [X_W-1:0]   X_LAST      = X_W'(127);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             busy_nxt, done_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = HAS_SETTLE ? S_SETTLE : S_SAMPLE;
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (x == X_LAST) state_nxt = S_DONE;
        else             state_nxt = HAS_SETTLE ? S_SETTLE : S_SAMPLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flopped flags line up with it
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      S_SETTLE, S_SAMPLE: busy_nxt = 1'b1;
      S_DONE:             done_nxt = 1'b1;
      default: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
      end
    endcase
  end

  // Status flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Vector counter, settle timer and capture datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x      <= '0;
      cnt    <= '0;
      tt     <= '0;
      weight <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x      <= '0;
            cnt    <= '0;
            tt     <= '0;
            weight <= '0;
          end
        end
        S_SETTLE: cnt <= cnt + CNT_W'(1);
        S_SAMPLE: begin
          tt[x]  <= f_in;
          weight <= weight + W_W'(f_in);
          cnt    <= '0;
          // x saturates at the last vector; it is only cleared on leaving DONE
          if (x != X_LAST) x <= x + X_W'(1);
        end
        S_DONE:  x <= '0;
        default: x <= '0;
      endcase
    end
  end

`ifdef TT_SWEEP_COMPARE_EN
  // Compare the finished table; tt is already final while in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match <= 1'b0;
    end else if (state == S_IDLE && start) begin
      match <= 1'b0;
    end else if (state == S_DONE) begin
      match <= (tt == expected);
    end
  end
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_capture
// Two instances (SETTLE=0 and SETTLE=2) sweep truth tables held in the bench.
// The reference is simply the table itself: tt must equal it, weight must be
// its popcount, and after the n-th edge following start x must equal
// n/(SETTLE+1) until done, which appears 128*(SETTLE+1) edges after start.
// ---------------------------------------------------------------------------
module tb_tt_sweep_capture;

  logic clk;
  logic rst_n;
  logic start;
  logic sel;               // 0 -> SETTLE=0 instance, 1 -> SETTLE=2 instance

  logic [127:0] func0, func2;
  logic [6:0]   x0, x2;
  logic         f_in0, f_in2;
  logic         busy0, busy2, done0, done2;
  logic [127:0] tt0, tt2;
  logic [7:0]   weight0, weight2;
  logic         start0, start2;

  int total;
  int bad;

  assign start0 = start & ~sel;
  assign start2 = start & sel;
  assign f_in0  = func0[x0];
  assign f_in2  = func2[x2];

`ifdef TT_SWEEP_COMPARE_EN
  logic [127:0] exp0, exp2;
  logic         match0, match2;
`endif

  tt_sweep_capture #(.SETTLE(0)) dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start0),
    .x      (x0),
    .f_in   (f_in0),
    .busy   (busy0),
    .done   (done0),
    .tt     (tt0),
    .weight (weight0)
`ifdef TT_SWEEP_COMPARE_EN
    ,
    .expected (exp0),
    .match    (match0)
`endif
  );

  tt_sweep_capture #(.SETTLE(2)) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start2),
    .x      (x2),
    .f_in   (f_in2),
    .busy   (busy2),
    .done   (done2),
    .tt     (tt2),
    .weight (weight2)
`ifdef TT_SWEEP_COMPARE_EN
    ,
    .expected (exp2),
    .match    (match2)
`endif
  );

  // Views of the selected instance
  logic [6:0]   cur_x;
  logic         cur_busy, cur_done;
  logic [127:0] cur_tt;
  logic [7:0]   cur_weight;
  assign cur_x      = sel ? x2 : x0;
  assign cur_busy   = sel ? busy2 : busy0;
  assign cur_done   = sel ? done2 : done0;
  assign cur_tt     = sel ? tt2 : tt0;
  assign cur_weight = sel ? weight2 : weight0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_table();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Table where f(x) = x[b]
  function automatic logic [127:0] bit_table(input int b);
    logic [127:0] t;
    for (int i = 0; i < 128; i++) t[i] = ((i >> b) & 1) == 1;
    return t;
  endfunction

  // Full sweep on the selected instance with optional restart attempts
  task automatic run_sweep(input logic s, input logic [127:0] func,
                           input int restart_at, input logic start_in_done,
                           input string tag);
    int n, per, xerr, berr;
    logic [6:0] xe;
    sel = s;
    if (s) func2 = func; else func0 = func;
    per = s ? 3 : 1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0; xerr = 0; berr = 0;
    while (cur_done !== 1'b1 && n < 2000) begin
      xe = 7'(((n / per) > 127) ? 127 : (n / per));
      if (cur_x !== xe) xerr++;
      if (cur_busy !== 1'b1) berr++;
      start = (n == restart_at);
      step();
      n++;
    end
    start = 1'b0;
    total++;
    if (n != 128 * per) begin
      bad++;
      $display("FAIL %s latency: got %0d edges want %0d", tag, n, 128 * per);
    end
    total++;
    if (xerr != 0 || berr != 0) begin
      bad++;
      $display("FAIL %s sequence: x errors %0d busy errors %0d want 0/0", tag, xerr, berr);
    end
    total++;
    if (cur_tt !== func || cur_busy !== 1'b0 || cur_x !== 7'd127) begin
      bad++;
      $display("FAIL %s done_state: tt=%h busy=%b x=%0d want tt=%h busy=0 x=127",
               tag, cur_tt, cur_busy, cur_x, func);
    end
    total++;
    if (cur_weight !== 8'($countones(func))) begin
      bad++;
      $display("FAIL %s weight: got %0d want %0d", tag, cur_weight, $countones(func));
    end
    // Start while in DONE must be ignored
    start = start_in_done;
    step();
    start = 1'b0;
    total++;
    if (cur_done !== 1'b0 || cur_busy !== 1'b0 || cur_x !== 7'd0) begin
      bad++;
      $display("FAIL %s after_done: done=%b busy=%b x=%0d want 0 0 0",
               tag, cur_done, cur_busy, cur_x);
    end
    step();
    total++;
    if (cur_busy !== 1'b0 || cur_done !== 1'b0 || cur_tt !== func ||
        cur_weight !== 8'($countones(func))) begin
      bad++;
      $display("FAIL %s hold: busy=%b done=%b tt=%h weight=%0d want 0 0 %h %0d",
               tag, cur_busy, cur_done, cur_tt, cur_weight, func, $countones(func));
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst_n = 1'b0;
    start = 1'b1;          // reset must win over start
    step();
    step();
    total++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || x0 !== 7'd0 || tt0 !== '0 || weight0 !== 8'd0) begin
      bad++;
      $display("FAIL reset0: busy=%b done=%b x=%0d tt=%h w=%0d want all zero",
               busy0, done0, x0, tt0, weight0);
    end
    total++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || x2 !== 7'd0 || tt2 !== '0 || weight2 !== 8'd0) begin
      bad++;
      $display("FAIL reset2: busy=%b done=%b x=%0d tt=%h w=%0d want all zero",
               busy2, done2, x2, tt2, weight2);
    end
    start = 1'b0;
    rst_n = 1'b1;
    step();
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b want 0", busy0);
    end
  endtask

  task automatic test_patterns();
    run_sweep(1'b0, {128{1'b1}}, -1, 1'b0, "ones");
    run_sweep(1'b0, bit_table(0), -1, 1'b0, "x0");
    total++;
    if (bit_table(0) !== 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA) begin
      bad++;
      $display("FAIL x0_table: model %h want aaaa...", bit_table(0));
    end
    run_sweep(1'b0, '0, -1, 1'b0, "zeros");
  endtask

  task automatic test_settle();
    run_sweep(1'b1, bit_table(6), -1, 1'b0, "settle2_x6");
    run_sweep(1'b1, rand_table(), -1, 1'b0, "settle2_rand");
  endtask

  task automatic test_start_ignored();
    logic [127:0] f;
    f = rand_table();
    run_sweep(1'b0, f, 50, 1'b1, "restart");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) run_sweep(1'b0, rand_table(), -1, 1'b0, "random");
  endtask

  task automatic test_reset_mid();
    int dones;
    sel = 1'b0;
    func0 = rand_table();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 70; n++) step();
    rst_n = 1'b0;
    step();
    total++;
    if (busy0 !== 1'b0 || x0 !== 7'd0 || tt0 !== '0 || weight0 !== 8'd0 || done0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b x=%0d tt=%h w=%0d done=%b want all zero",
               busy0, x0, tt0, weight0, done0);
    end
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (done0 === 1'b1 || busy0 === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet: got %0d active cycles want 0", dones);
    end
  endtask

`ifdef TT_SWEEP_COMPARE_EN
  task automatic test_compare();
    logic [127:0] maj;
    for (int i = 0; i < 128; i++) maj[i] = $countones(7'(i)) >= 4;
    exp0 = maj;
    run_sweep(1'b0, maj, -1, 1'b0, "majority");
    total++;
    if (match0 !== 1'b1) begin
      bad++;
      $display("FAIL match_equal: got %b want 1", match0);
    end
    exp0 = maj ^ 128'd1;
    sel = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (match0 !== 1'b0) begin
      bad++;
      $display("FAIL match_clear_on_start: got %b want 0", match0);
    end
    for (int n = 0; n < 140; n++) step();
    total++;
    if (match0 !== 1'b0 || tt0 !== maj) begin
      bad++;
      $display("FAIL match_flip: match=%b tt=%h want 0 %h", match0, tt0, maj);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sel = 1'b0;
    func0 = '0;
    func2 = '0;
`ifdef TT_SWEEP_COMPARE_EN
    exp0 = '0;
    exp2 = '0;
`endif
    test_reset();
    test_patterns();
    test_settle();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef TT_SWEEP_COMPARE_EN
    test_compare();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
